// File: rtl/div64x32_seq.sv
// rtl/div64x32_seq.sv - sequential 64/32 unsigned restoring divider, one quotient bit per clock
// Start/busy handshake; results hold until the next completion or divide-by-zero start.
module div64x32_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [63:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [63:0] quotient,
   output logic [31:0] remainder,
   output logic        div_by_zero
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state_q;
   logic [5:0]  cnt_q;
   logic [63:0] dvd_q;
   logic [31:0] dsr_q;
   logic [31:0] rem_q;
   logic        busy_q;
   logic [63:0] quo_q;
   logic [31:0] rmd_q;
   logic        dbz_q;

   logic [32:0] shift_d;
   logic [31:0] sub_d;
   logic [31:0] rem_d;
   logic        qbit_d;

   // Partial remainder is always below the divisor, so the low 32 bits of the
   // difference are exact; the compare itself uses the full 33-bit shifted value.
   always_comb begin
      shift_d = {rem_q, dvd_q[63]};
      sub_d   = shift_d[31:0] - dsr_q;
      qbit_d  = (shift_d >= {1'b0, dsr_q});
      rem_d   = qbit_d ? sub_d : shift_d[31:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 6'd0;
         dvd_q   <= 64'd0;
         dsr_q   <= 32'd0;
         rem_q   <= 32'd0;
         busy_q  <= 1'b0;
         quo_q   <= 64'd0;
         rmd_q   <= 32'd0;
         dbz_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (b != 32'd0) begin
                     dvd_q   <= a;
                     dsr_q   <= b;
                     rem_q   <= 32'd0;
                     cnt_q   <= 6'd0;
                     busy_q  <= 1'b1;
                     state_q <= RUN;
                  end else begin
                     quo_q <= {64{1'b1}};
                     rmd_q <= a[31:0];
                     dbz_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               dvd_q <= {dvd_q[62:0], qbit_d};
               rem_q <= rem_d;
               cnt_q <= cnt_q + 6'd1;
               if (cnt_q == 6'd63) begin
                  quo_q   <= {dvd_q[62:0], qbit_d};
                  rmd_q   <= rem_d;
                  dbz_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy        = busy_q;
   assign quotient    = quo_q;
   assign remainder   = rmd_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div64x32_seq.sv
// tb/tb_div64x32_seq.sv - scoreboard bench for div64x32_seq with directed vectors
module tb_div64x32_seq;

   typedef struct {
      logic [63:0] q;
      logic [31:0] r;
      logic        z;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [63:0] a = 64'd0;
   logic [31:0] b = 32'd0;
   logic        busy;
   logic [63:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   bit   done = 1'b0;

   div64x32_seq dut (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
      .busy(busy), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   task automatic push(input logic [63:0] q, input logic [31:0] r, input logic z);
      exp_t e;
      e.q = q; e.r = r; e.z = z;
      exp_q.push_back(e);
   endtask

   task automatic do_div(input logic [63:0] av, input logic [31:0] bv,
                         input logic [63:0] q, input logic [31:0] r, input string name);
      int n;
      @(negedge clk);
      a = av; b = bv; start = 1'b1;
      push(q, r, 1'b0);
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (busy && n < 200) begin
         n++;
         @(negedge clk);
      end
      check({name, " busy cycles"}, 64'(n), 64'd64);
   endtask

   // Monitor: completion is a busy fall; a divide-by-zero shows as an output change while idle.
   initial begin
      logic        prev_busy;
      logic [63:0] prev_q;
      logic [31:0] prev_r;
      logic        prev_z;
      exp_t        e;
      prev_busy = 1'b0; prev_q = '0; prev_r = '0; prev_z = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if ((prev_busy && !busy) ||
                (!prev_busy && !busy && {quotient, remainder, div_by_zero} != {prev_q, prev_r, prev_z})) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected result: q=%h r=%h z=%b, expected none", quotient, remainder, div_by_zero);
               end else begin
                  e = exp_q.pop_front();
                  check("sb quotient", quotient, e.q);
                  check("sb remainder", 64'(remainder), 64'(e.r));
                  check("sb div_by_zero", 64'(div_by_zero), 64'(e.z));
               end
            end
         end
         prev_busy = reset ? 1'b0 : busy;
         prev_q = quotient; prev_r = remainder; prev_z = div_by_zero;
      end
   end

   initial begin
      int n;
      repeat (2) @(negedge clk);
      check("reset busy", 64'(busy), 64'd0);
      check("reset quotient", quotient, 64'd0);
      check("reset remainder", 64'(remainder), 64'd0);
      check("reset div_by_zero", 64'(div_by_zero), 64'd0);
      @(posedge clk); #1 reset = 1'b0;

      do_div(64'd81674224, 32'd6091, 64'd13409, 32'd5, "basic");
      do_div(64'hFFFF_FFFF_FFFF_FFFF, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32'd0, "max/1");
      do_div(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0001_0000_0001, 32'd0, "max/max");
      do_div(64'd7, 32'd9, 64'd0, 32'd7, "7/9");
      do_div(64'd0, 32'd5, 64'd0, 32'd0, "0/5");

      // Divide by zero: result appears after the start edge with no busy
      @(negedge clk);
      a = 64'h1234_5678_9ABC_DEF0; b = 32'd0; start = 1'b1;
      push(64'hFFFF_FFFF_FFFF_FFFF, 32'h9ABC_DEF0, 1'b1);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("dbz busy low", 64'(busy), 64'd0);
         @(negedge clk);
      end

      // start pulse during RUN is ignored; previous dbz result holds until completion
      a = 64'd100; b = 32'd7; start = 1'b1;
      push(64'd14, 32'd2, 1'b0);
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (busy && n < 200) begin
         n++;
         if (n == 10 || n == 63) begin
            check("hold quotient", quotient, 64'hFFFF_FFFF_FFFF_FFFF);
            check("hold remainder", 64'(remainder), 64'h9ABC_DEF0);
            check("hold div_by_zero", 64'(div_by_zero), 64'd1);
         end
         if (n == 10) begin
            start = 1'b1; a = 64'd1; b = 32'd1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check("ignore-start busy cycles", 64'(n), 64'd64);

      // Asynchronous reset mid-operation; the aborted division publishes nothing
      a = 64'd5000; b = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (busy && n < 30) begin
         n++;
         @(negedge clk);
      end
      #2 reset = 1'b1;
      #1;
      check("abort busy", 64'(busy), 64'd0);
      check("abort quotient", quotient, 64'd0);
      check("abort remainder", 64'(remainder), 64'd0);
      check("abort div_by_zero", 64'(div_by_zero), 64'd0);
      @(negedge clk);
      @(posedge clk); #1 reset = 1'b0;

      do_div(64'd1000, 32'd10, 64'd100, 32'd0, "post-reset");
      repeat (3) @(negedge clk);
      check("scoreboard drained", 64'(exp_q.size()), 64'd0);
      done = 1'b1;
   end

   initial begin
      fork
         wait (done);
         begin
            #200000;
            errors++;
            $display("FAIL timeout: done=%b, expected 1", done);
         end
      join_any
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
